exu_lsu: RTL

//  Load/store unit between the execute stage and the data memory port. It takes one
//  lh/lw/lbu/lhu/sb/sh/sw per start pulse and issues one memory request on a

---
 rtl/exu_lsu_pkg.sv | 46 ++++
 rtl/exu_lsu_align.sv | 48 ++++
 rtl/exu_lsu.sv | 115 +++++++++++
 3 files changed

// File: rtl/exu_lsu_pkg.sv
// exu_lsu_pkg: shared constants for the load/store unit.
//   - decoded op codes (inst_num encoding) for the memory ops
//   - FSM state encodings (legacy-compatible 3-bit constants)
//   - byte-lane mask seeds for byte/half/word stores
//   - helpers that classify ops and detect misaligned accesses
package exu_lsu_pkg;

   localparam int unsigned INST_NUM_WIDTH = 6;

   localparam logic [INST_NUM_WIDTH-1:0] OP_LH  = 6'd10;
   localparam logic [INST_NUM_WIDTH-1:0] OP_LW  = 6'd11;
   localparam logic [INST_NUM_WIDTH-1:0] OP_LBU = 6'd12;
   localparam logic [INST_NUM_WIDTH-1:0] OP_LHU = 6'd13;
   localparam logic [INST_NUM_WIDTH-1:0] OP_SB  = 6'd14;
   localparam logic [INST_NUM_WIDTH-1:0] OP_SH  = 6'd15;
   localparam logic [INST_NUM_WIDTH-1:0] OP_SW  = 6'd16;

   localparam logic [2:0] LSU_IDLE = 3'd0;
   localparam logic [2:0] LSU_CHK  = 3'd1;
   localparam logic [2:0] LSU_REQ  = 3'd2;
   localparam logic [2:0] LSU_WAIT = 3'd3;
   localparam logic [2:0] LSU_DONE = 3'd4;

   localparam logic [3:0] LSU_MASK_B = 4'b0001;
   localparam logic [3:0] LSU_MASK_H = 4'b0011;
   localparam logic [3:0] LSU_MASK_W = 4'b1111;

   function automatic logic is_load(input logic [INST_NUM_WIDTH-1:0] op);
      return (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic is_store(input logic [INST_NUM_WIDTH-1:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   // Byte accesses can never be misaligned; halves need an even address,
   // words need a 4-byte aligned address.
   function automatic logic is_misaligned(input logic [INST_NUM_WIDTH-1:0] op,
                                          input logic [1:0] off);
      logic half, word;
      half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
      word = (op == OP_LW) || (op == OP_SW);
      return (half && off[0]) || (word && (off != 2'b00));
   endfunction

endpackage

// File: rtl/exu_lsu_align.sv
// exu_lsu_align: combinational byte-lane steering for the LSU.
//   op_i     decoded op
//   off_i    byte offset within the word (addr[1:0])
//   src2_i   right-aligned store data
//   rdata_i  full read word from memory
//   wmask_o  byte strobes for stores (0 for loads / non-memory ops)
//   wdata_o  store data replicated across the lane(s)
//   rdata_o  load data shifted to bit 0, upper bits zero (not extended)
module exu_lsu_align
   import exu_lsu_pkg::*;
(
   input  logic [INST_NUM_WIDTH-1:0] op_i,
   input  logic [1:0]                off_i,
   input  logic [31:0]               src2_i,
   input  logic [31:0]               rdata_i,
   output logic [3:0]                wmask_o,
   output logic [31:0]               wdata_o,
   output logic [31:0]               rdata_o
);

   logic [31:0] shifted;

   always_comb begin
      wmask_o = '0;
      wdata_o = '0;
      rdata_o = '0;
      shifted = rdata_i >> {off_i, 3'b000};
      case (op_i)
         OP_SB: begin
            wmask_o = LSU_MASK_B << off_i;
            wdata_o = {4{src2_i[7:0]}};
         end
         OP_SH: begin
            wmask_o = LSU_MASK_H << off_i;
            wdata_o = {2{src2_i[15:0]}};
         end
         OP_SW: begin
            wmask_o = LSU_MASK_W;
            wdata_o = src2_i;
         end
         OP_LBU:       rdata_o = {24'h0, shifted[7:0]};
         OP_LH, OP_LHU: rdata_o = {16'h0, shifted[15:0]};
         OP_LW:        rdata_o = shifted;
         default: ;
      endcase
   end

endmodule

// File: rtl/exu_lsu.sv
// exu_lsu: load/store unit between execute and the data memory port.
// One memory op per start pulse; a single valid/ready request is issued,
// then the unit waits for a 1-cycle response and pulses lsu_done.
//   clk, rst        clock, synchronous active-high reset
//   start           launch strobe, only honoured in IDLE
//   inst_num        decoded op
//   alu_result      effective byte address
//   src2            right-aligned store data
//   mem_req_*       request port (valid/ready, wen, word addr, wdata, wmask)
//   mem_rsp_*       1-cycle response / write ack and read word
//   mem_r           right-aligned load data, held until the next load
//   lsu_busy        high whenever not IDLE
//   lsu_done        1-cycle completion pulse
//   lsu_misalign    qualifies lsu_done: access was dropped as misaligned
module exu_lsu
   import exu_lsu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [INST_NUM_WIDTH-1:0] inst_num,
   input  logic [ADDR_WIDTH-1:0]     alu_result,
   input  logic [DATA_WIDTH-1:0]     src2,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic                      mem_req_wen,
   output logic [ADDR_WIDTH-1:0]     mem_req_addr,
   output logic [DATA_WIDTH-1:0]     mem_req_wdata,
   output logic [3:0]                mem_req_wmask,
   input  logic                      mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]     mem_rsp_rdata,
   output logic [DATA_WIDTH-1:0]     mem_r,
   output logic                      lsu_busy,
   output logic                      lsu_done,
   output logic                      lsu_misalign
);

   logic [2:0]                state_q, state_d;
   logic [INST_NUM_WIDTH-1:0] op_q;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [DATA_WIDTH-1:0]     src2_q;
   logic                      misalign_q;
   logic [DATA_WIDTH-1:0]     mem_r_q;

   logic [3:0]            al_wmask;
   logic [DATA_WIDTH-1:0] al_wdata;
   logic [DATA_WIDTH-1:0] al_rdata;
   logic                  mis_w;
   logic                  in_req;

   exu_lsu_align u_align (
      .op_i    (op_q),
      .off_i   (addr_q[1:0]),
      .src2_i  (src2_q),
      .rdata_i (mem_rsp_rdata),
      .wmask_o (al_wmask),
      .wdata_o (al_wdata),
      .rdata_o (al_rdata)
   );

   assign mis_w = is_misaligned(op_q, addr_q[1:0]);

   always_comb begin
      state_d = state_q;
      case (state_q)
         LSU_IDLE: if (start) state_d = LSU_CHK;
         LSU_CHK: begin
            if (mis_w || !(is_load(op_q) || is_store(op_q))) state_d = LSU_DONE;
            else                                             state_d = LSU_REQ;
         end
         LSU_REQ:  if (mem_req_ready) state_d = LSU_WAIT;
         LSU_WAIT: if (mem_rsp_valid) state_d = LSU_DONE;
         LSU_DONE: state_d = LSU_IDLE;
         default:  state_d = LSU_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LSU_IDLE;
         op_q       <= '0;
         addr_q     <= '0;
         src2_q     <= '0;
         misalign_q <= 1'b0;
         mem_r_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == LSU_IDLE && start) begin
            op_q   <= inst_num;
            addr_q <= alu_result;
            src2_q <= src2;
         end
         if (state_q == LSU_CHK) misalign_q <= mis_w;
         if (state_q == LSU_WAIT && mem_rsp_valid && is_load(op_q)) mem_r_q <= al_rdata;
      end
   end

   // Request fields come straight from the latched operands, so they are
   // stable for the whole REQ state; they read as zero outside it.
   assign in_req        = (state_q == LSU_REQ);
   assign mem_req_valid = in_req;
   assign mem_req_wen   = in_req && is_store(op_q);
   assign mem_req_addr  = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign mem_req_wdata = in_req ? al_wdata : '0;
   assign mem_req_wmask = in_req ? al_wmask : '0;

   assign mem_r        = mem_r_q;
   assign lsu_busy     = (state_q != LSU_IDLE);
   assign lsu_done     = (state_q == LSU_DONE);
   assign lsu_misalign = (state_q == LSU_DONE) && misalign_q;

endmodule
